// File: rtl/mem_arbiter_pkg.sv
// Shared types and grant selection for the fetch/data memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned DEF_AW      = 32;
  localparam int unsigned DEF_DW      = 32;
  localparam int unsigned DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } arb_owner_e;

  // On a tie the preferred port wins; otherwise whichever port is requesting.
  function automatic arb_owner_e pick_owner(input logic if_req, input logic dm_req,
                                            input logic if_preferred);
    arb_owner_e win;
    win = OWN_NONE;
    if (if_req && dm_req) win = if_preferred ? OWN_IF : OWN_DM;
    else if (dm_req)      win = OWN_DM;
    else if (if_req)      win = OWN_IF;
    return win;
  endfunction

endpackage

// File: rtl/mem_arbiter_timer.sv
// Access watchdog: loadable up-counter with a registered terminal-count flag.
module mem_arbiter_timer
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tc_q, tc_d;

  // tc is precomputed from the next count so it is high while count == TIMEOUT-1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + CW'(1);
    tc_d = (cnt_d == CW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_d;
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between CPU fetch and data ports, with watchdog abort.
// Define ARB_ROUND_ROBIN_EN for round-robin ties; default is fixed data-over-fetch priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned AW      = DEF_AW,
  parameter int unsigned DW      = DEF_DW,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_ack_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          dm_req_i,
  input  logic          dm_we_i,
  input  logic [AW-1:0] dm_addr_i,
  input  logic [DW-1:0] dm_wdata_i,
  output logic          dm_ack_o,
  output logic [DW-1:0] dm_rdata_o,
  output logic          mem_req_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic          mem_ack_i,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          err_o,
  output logic          busy_o
);

  arb_state_e    state_q, state_d;
  arb_owner_e    owner_q, owner_d;
  arb_owner_e    grant_c;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_ack_q, if_ack_d, dm_ack_q, dm_ack_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic [DW-1:0] done_data_c;
  logic          err_q, err_d, busy_q, busy_d;
  logic          tmr_clr_c, tmr_en_c, tmr_tc;
  logic          if_pref_c;

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_if_first_q, rr_if_first_d;
  assign if_pref_c = rr_if_first_q;
`else
  assign if_pref_c = 1'b0;
`endif

  assign grant_c = pick_owner(if_req_i, dm_req_i, if_pref_c);

  mem_arbiter_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (tmr_clr_c),
    .en_i  (tmr_en_c),
    .tc_o  (tmr_tc)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ack_d    = 1'b0;
    dm_ack_d    = 1'b0;
    err_d       = 1'b0;
    tmr_clr_c   = 1'b0;
    tmr_en_c    = 1'b0;
    done_data_c = mem_ack_i ? mem_rdata_i : '0;
`ifdef ARB_ROUND_ROBIN_EN
    rr_if_first_d = rr_if_first_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (grant_c != OWN_NONE) begin
          state_d   = ARB_ACCESS;
          owner_d   = grant_c;
          mem_req_d = 1'b1;
          tmr_clr_c = 1'b1;
          if (grant_c == OWN_DM) begin
            mem_we_d    = dm_we_i;
            mem_addr_d  = dm_addr_i;
            mem_wdata_d = dm_wdata_i;
          end else begin
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr_i;
            mem_wdata_d = '0;
          end
`ifdef ARB_ROUND_ROBIN_EN
          rr_if_first_d = (grant_c == OWN_DM);
`endif
        end
      end
      ARB_ACCESS: begin
        tmr_en_c = 1'b1;
        // An ack in the terminal cycle still counts as a normal completion.
        if (mem_ack_i || tmr_tc) begin
          state_d   = ARB_DONE;
          mem_req_d = 1'b0;
          err_d     = !mem_ack_i;
          if (owner_q == OWN_IF) begin
            if_ack_d   = 1'b1;
            if_rdata_d = done_data_c;
          end else begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = done_data_c;
          end
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
        owner_d = OWN_NONE;
      end
      default: state_d = ARB_IDLE;
    endcase
    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_NONE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ack_q    <= 1'b0;
      dm_ack_q    <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_ack_q    <= if_ack_d;
      dm_ack_q    <= dm_ack_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) rr_if_first_q <= 1'b1;
    else        rr_if_first_q <= rr_if_first_d;
  end
`endif

  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign if_ack_o    = if_ack_q;
  assign dm_ack_o    = dm_ack_q;
  assign if_rdata_o  = if_rdata_q;
  assign dm_rdata_o  = dm_rdata_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single-port transfers plus contention/reset sequences.
module tb_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        if_req_i, dm_req_i, dm_we_i, mem_ack_i;
  logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i, mem_rdata_i;
  logic        if_ack_o, dm_ack_o, mem_req_o, mem_we_o, err_o, busy_o;
  logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;

  mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_ack_o(dm_ack_o), .dm_rdata_o(dm_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          mem_lat  = 0;
  logic [31:0] mem_data = 32'h0;
  logic [31:0] exp_if_rdata = 32'h0;
  logic [31:0] exp_dm_rdata = 32'h0;

  typedef struct {
    logic        is_if;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] data;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Memory model: acks in ACCESS cycle lat+1 (lat >= 15 never acks); bad data when not acking.
  initial begin
    int wcnt;
    wcnt = 0;
    mem_ack_i = 1'b0;
    mem_rdata_i = 32'h0;
    forever begin
      @(negedge clk_i);
      if (mem_req_o) begin
        mem_ack_i   = (wcnt == mem_lat);
        mem_rdata_i = mem_ack_i ? mem_data : ~mem_data;
        wcnt++;
      end else begin
        mem_ack_i = 1'b0;
        wcnt = 0;
      end
    end
  end

  // One granted transfer; mode 0 drops own req at ack, 1 keeps both, 2 drops both.
  task automatic serve(input string tag, input logic exp_if, input logic [31:0] exp_addr,
                       input logic exp_we, input logic [31:0] exp_wdata, input int lat,
                       input logic [31:0] data, input logic [31:0] exp_rd, input logic exp_err,
                       input int exp_cyc, input int mode);
    int w;
    int cyc;
    mem_lat  = lat;
    mem_data = data;
    w = 0;
    do begin
      @(negedge clk_i);
      w++;
    end while (!mem_req_o && w < 10);
    check({tag, " mem_req"}, {31'b0, mem_req_o}, 32'd1);
    if (!mem_req_o) return;
    check({tag, " mem_addr"}, mem_addr_o, exp_addr);
    check({tag, " mem_we"}, {31'b0, mem_we_o}, {31'b0, exp_we});
    if (exp_we) check({tag, " mem_wdata"}, mem_wdata_o, exp_wdata);
    check({tag, " busy"}, {31'b0, busy_o}, 32'd1);
    cyc = 0;
    while (mem_req_o && cyc < 300) begin
      cyc++;
      @(negedge clk_i);
    end
    check({tag, " access cycles"}, cyc, exp_cyc);
    check({tag, " if_ack"}, {31'b0, if_ack_o}, {31'b0, exp_if});
    check({tag, " dm_ack"}, {31'b0, dm_ack_o}, {31'b0, !exp_if});
    check({tag, " err"}, {31'b0, err_o}, {31'b0, exp_err});
    check({tag, " busy done"}, {31'b0, busy_o}, 32'd1);
    if (exp_if) exp_if_rdata = exp_rd;
    else        exp_dm_rdata = exp_rd;
    check({tag, " if_rdata"}, if_rdata_o, exp_if_rdata);
    check({tag, " dm_rdata"}, dm_rdata_o, exp_dm_rdata);
    if (mode == 2) begin
      if_req_i = 1'b0;
      dm_req_i = 1'b0;
    end else if (mode == 0) begin
      if (exp_if) if_req_i = 1'b0;
      else        dm_req_i = 1'b0;
    end
    @(negedge clk_i);
    check({tag, " ack pulse"}, {30'b0, if_ack_o, dm_ack_o}, 32'd0);
    check({tag, " err pulse"}, {31'b0, err_o}, 32'd0);
    check({tag, " busy idle"}, {31'b0, busy_o}, 32'd0);
  endtask

  initial begin
    int w;
    logic exp_if;
    if_req_i = 1'b0; dm_req_i = 1'b0; dm_we_i = 1'b0;
    if_addr_i = 32'h0; dm_addr_i = 32'h0; dm_wdata_i = 32'h0;

    vecs[0] = '{1'b1, 1'b0, 32'h40,  32'h0,        2,    32'h12345678, 32'h12345678, 1'b0, 3};
    vecs[1] = '{1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 0,    32'h5555AAAA, 32'h5555AAAA, 1'b0, 1};
    vecs[2] = '{1'b0, 1'b0, 32'h200, 32'h0,        1000, 32'h77777777, 32'h0,        1'b1, 15};
    vecs[3] = '{1'b0, 1'b0, 32'h204, 32'h0,        14,   32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 15};
    vecs[4] = '{1'b1, 1'b0, 32'h44,  32'h0,        1,    32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 2};
    vecs[5] = '{1'b0, 1'b0, 32'h208, 32'h0,        0,    32'h0BADF00D, 32'h0BADF00D, 1'b0, 1};

    repeat (3) @(negedge clk_i);
    check("reset mem_req", {31'b0, mem_req_o}, 32'd0);
    check("reset acks", {30'b0, if_ack_o, dm_ack_o}, 32'd0);
    check("reset err/busy", {30'b0, err_o, busy_o}, 32'd0);
    check("reset rdata", if_rdata_o | dm_rdata_o, 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 6; i++) begin
      @(negedge clk_i);
      if (vecs[i].is_if) begin
        if_req_i = 1'b1; if_addr_i = vecs[i].addr;
      end else begin
        dm_req_i = 1'b1; dm_we_i = vecs[i].we; dm_addr_i = vecs[i].addr;
        dm_wdata_i = vecs[i].wdata;
      end
      serve($sformatf("vec%0d", i), vecs[i].is_if, vecs[i].addr, vecs[i].we, vecs[i].wdata,
            vecs[i].lat, vecs[i].data, vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_cyc, 0);
    end

    // Reset during ACCESS: request drops immediately, nothing completes afterwards.
    @(negedge clk_i);
    mem_lat = 1000;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h500;
    w = 0;
    do begin
      @(negedge clk_i);
      w++;
    end while (!mem_req_o && w < 10);
    check("rst mem_req before", {31'b0, mem_req_o}, 32'd1);
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    check("rst mem_req async", {31'b0, mem_req_o}, 32'd0);
    check("rst busy async", {31'b0, busy_o}, 32'd0);
    dm_req_i = 1'b0;
    exp_if_rdata = 32'h0;
    exp_dm_rdata = 32'h0;
    @(negedge clk_i);
    rst_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      check("rst after acks", {30'b0, if_ack_o, dm_ack_o}, 32'd0);
      check("rst after busy/req", {30'b0, busy_o, mem_req_o}, 32'd0);
    end

    // Simultaneous fetch and data write.
    @(negedge clk_i);
    if_req_i = 1'b1; if_addr_i = 32'h80;
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h100; dm_wdata_i = 32'hDEADBEEF;
`ifdef ARB_ROUND_ROBIN_EN
    serve("tie if", 1'b1, 32'h80, 1'b0, 32'h0, 0, 32'h22222222, 32'h22222222, 1'b0, 1, 0);
    serve("tie dm", 1'b0, 32'h100, 1'b1, 32'hDEADBEEF, 0, 32'h11111111, 32'h11111111, 1'b0, 1, 0);
`else
    serve("tie dm", 1'b0, 32'h100, 1'b1, 32'hDEADBEEF, 0, 32'h11111111, 32'h11111111, 1'b0, 1, 0);
    serve("tie if", 1'b1, 32'h80, 1'b0, 32'h0, 0, 32'h22222222, 32'h22222222, 1'b0, 1, 0);
`endif

    // Both ports requesting continuously for six transfers.
    @(negedge clk_i);
    if_req_i = 1'b1; if_addr_i = 32'h300;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h400;
    for (int i = 0; i < 6; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_if = (i % 2 == 0);
`else
      exp_if = 1'b0;
`endif
      serve($sformatf("cont%0d", i), exp_if, exp_if ? 32'h300 : 32'h400, 1'b0, 32'h0, 0,
            32'hC0DE0000 + 32'(i), 32'hC0DE0000 + 32'(i), 1'b0, 1, (i == 5) ? 2 : 1);
    end

    repeat (2) @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "time limit");
  end

endmodule
